// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: holds the PC on the memory address for RD_LAT cycles,
// captures the word and offers it to decode over valid/ready; accepts branch redirects.
module imem_fetch_ctrl #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 32,
    parameter int                RD_LAT   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic [ADDR_W-1:0] MemAddress,
    input  logic [DATA_W-1:0] MemData,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrPC,
    output logic              AlignErr,
    output logic [CNT_W-1:0]  FetchCount
);

    if (RD_LAT < 1) begin : g_bad_lat
        $error("imem_fetch_ctrl: RD_LAT must be at least 1");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("imem_fetch_ctrl: RESET_PC must be word aligned");
    end

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [LAT_W-1:0]  wait_cnt;
    logic              target_ok;
    logic              handshake;

    assign MemAddress = pc;
    assign target_ok  = (RedirectPC[1:0] == 2'b00);
    assign handshake  = InstrValid && InstrReady;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            wait_cnt   <= '0;
            InstrValid <= 1'b0;
            Instr      <= '0;
            InstrPC    <= '0;
            AlignErr   <= 1'b0;
            FetchCount <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // A redirect on the capture edge drops the word being read.
                    if (Redirect) begin
                        if (target_ok) begin
                            pc       <= RedirectPC;
                            wait_cnt <= '0;
                        end else begin
                            AlignErr <= 1'b1;
                            state    <= FAULT;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        Instr      <= MemData;
                        InstrPC    <= pc;
                        InstrValid <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        FetchCount <= FetchCount + CNT_W'(1);
                    end
                    if (Redirect) begin
                        InstrValid <= 1'b0;
                        if (target_ok) begin
                            pc       <= RedirectPC;
                            wait_cnt <= '0;
                            state    <= FETCH;
                        end else begin
                            AlignErr <= 1'b1;
                            state    <= FAULT;
                        end
                    end else if (handshake) begin
                        pc         <= pc + ADDR_W'(4);
                        InstrValid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                FAULT: begin
                    InstrValid <= 1'b0;
                end
                default: begin
                    InstrValid <= 1'b0;
                    state      <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic against a
// timestamp-based model, on an RD_LAT=2 instance and an RD_LAT=1 instance.
module tb_imem_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Redirect = 1'b0;
    logic [63:0] RedirectPC = '0;
    logic        InstrReady = 1'b0;

    logic [63:0] a0, a1, ip0, ip1;
    logic [31:0] md0, md1, i0, i1, c0, c1;
    logic        v0, v1, e0, e1;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'h00:  imem = 32'hF84003E9;
            64'h04:  imem = 32'hF84083EA;
            64'h08:  imem = 32'hF84103EB;
            64'h28:  imem = 32'h17FFFFFD;
            64'h3C:  imem = 32'hB2048FE9;
            default: imem = (a[31:0] * 32'h9E3779B1) ^ 32'hC0DE0001;
        endcase
    endfunction

    assign md0 = imem(a0);
    assign md1 = imem(a1);

    imem_fetch_ctrl #(.RD_LAT(2)) dut (
        .CLK(CLK), .Reset(Reset), .MemAddress(a0), .MemData(md0),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .InstrValid(v0),
        .InstrReady(InstrReady), .Instr(i0), .InstrPC(ip0),
        .AlignErr(e0), .FetchCount(c0)
    );

    imem_fetch_ctrl #(.RD_LAT(1)) dut1 (
        .CLK(CLK), .Reset(Reset), .MemAddress(a1), .MemData(md1),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .InstrValid(v1),
        .InstrReady(InstrReady), .Instr(i1), .InstrPC(ip1),
        .AlignErr(e1), .FetchCount(c1)
    );

    // Model: a fetch started at edge S delivers its word on edge S+latency.
    logic [63:0] m_pc[2], m_ipc[2];
    logic [31:0] m_instr[2], m_cnt[2];
    logic        m_valid[2], m_err[2];
    int          m_start[2];
    int          lat[2] = '{2, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = '0; m_ipc[k] = '0; m_instr[k] = '0; m_cnt[k] = '0;
            m_valid[k] = 1'b0; m_err[k] = 1'b0; m_start[k] = 0;
        end
        edge_n = 0;
    endtask

    task automatic model_edge(input logic red, input logic [63:0] rpc, input logic rdy);
        for (int k = 0; k < 2; k++) begin
            if (m_err[k]) continue;
            if (m_valid[k] && rdy) m_cnt[k] = m_cnt[k] + 1;
            if (red) begin
                m_valid[k] = 1'b0;
                if (rpc[1:0] == 2'b00) begin
                    m_pc[k] = rpc;
                    m_start[k] = edge_n;
                end else begin
                    m_err[k] = 1'b1;
                end
            end else if (m_valid[k] && rdy) begin
                m_valid[k] = 1'b0;
                m_pc[k] = m_pc[k] + 64'd4;
                m_start[k] = edge_n;
            end else if (!m_valid[k] && (edge_n - m_start[k] == lat[k])) begin
                m_valid[k] = 1'b1;
                m_instr[k] = imem(m_pc[k]);
                m_ipc[k] = m_pc[k];
            end
        end
    endtask

    task automatic step(input logic red, input logic [63:0] rpc, input logic rdy);
        Redirect = red;
        RedirectPC = rpc;
        InstrReady = rdy;
        @(posedge CLK);
        edge_n++;
        model_edge(red, rpc, rdy);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Redirect = 1'b0;
        InstrReady = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({v0, e0, a0, ip0, i0, c0} !== 194'h0) begin
            bad++;
            $display("FAIL reset_state_lat2: got v=%b err=%b addr=%h ipc=%h instr=%h cnt=%0d, want all zero",
                     v0, e0, a0, ip0, i0, c0);
        end
        total++;
        if ({v1, e1, a1, ip1, i1, c1} !== 194'h0) begin
            bad++;
            $display("FAIL reset_state_lat1: got v=%b err=%b addr=%h ipc=%h instr=%h cnt=%0d, want all zero",
                     v1, e1, a1, ip1, i1, c1);
        end
    endtask

    task automatic test_stream();
        int          cyc_q[$];
        logic [63:0] pc_q[$];
        logic [31:0] ins_q[$];
        int          exp_cyc[3] = '{2, 5, 8};
        logic [63:0] exp_pc[3]  = '{64'h0, 64'h4, 64'h8};
        logic [31:0] exp_ins[3] = '{32'hF84003E9, 32'hF84083EA, 32'hF84103EB};
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            step(1'b0, 64'h0, 1'b1);
            if (v0) begin
                cyc_q.push_back(c);
                pc_q.push_back(ip0);
                ins_q.push_back(i0);
            end
        end
        total++;
        if (cyc_q.size() != 3) begin
            bad++;
            $display("FAIL stream_count_valids: got %0d valid cycles, want 3", cyc_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if ({cyc_q[k], pc_q[k], ins_q[k]} !== {exp_cyc[k], exp_pc[k], exp_ins[k]}) begin
                    bad++;
                    $display("FAIL stream_word%0d: got cycle %0d pc %h instr %h, want cycle %0d pc %h instr %h",
                             k, cyc_q[k], pc_q[k], ins_q[k], exp_cyc[k], exp_pc[k], exp_ins[k]);
                end
            end
        end
        total++;
        if (c0 !== 32'd3) begin
            bad++;
            $display("FAIL stream_fetchcount: got %0d, want 3", c0);
        end
        total++;
        if (c1 !== 32'd4) begin
            bad++;
            $display("FAIL stream_fetchcount_lat1: got %0d, want 4", c1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b0);
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 64'h0, 1'b0);
            total++;
            if ({v0, ip0, a0, i0, c0} !== {1'b1, 64'h0, 64'h0, 32'hF84003E9, 32'h0}) begin
                bad++;
                $display("FAIL backpressure_hold%0d: got v=%b ipc=%h addr=%h instr=%h cnt=%0d, want 1/0/0/F84003E9/0",
                         n, v0, ip0, a0, i0, c0);
            end
        end
        step(1'b0, 64'h0, 1'b1);
        total++;
        if ({v0, a0, c0} !== {1'b0, 64'h4, 32'd1}) begin
            bad++;
            $display("FAIL backpressure_release: got v=%b addr=%h cnt=%0d, want 0/4/1", v0, a0, c0);
        end
        step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b0);
        total++;
        if ({v0, ip0, i0} !== {1'b1, 64'h4, 32'hF84083EA}) begin
            bad++;
            $display("FAIL backpressure_next: got v=%b ipc=%h instr=%h, want 1/4/F84083EA", v0, ip0, i0);
        end
    endtask

    task automatic test_branch();
        logic seen_2c = 1'b0;
        do_reset();
        step(1'b1, 64'h28, 1'b0);
        step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b0);
        total++;
        if ({v0, ip0, i0} !== {1'b1, 64'h28, 32'h17FFFFFD}) begin
            bad++;
            $display("FAIL branch_hold28: got v=%b ipc=%h instr=%h, want 1/28/17FFFFFD", v0, ip0, i0);
        end
        step(1'b1, 64'h1C, 1'b1);
        total++;
        if ({v0, a0, c0} !== {1'b0, 64'h1C, 32'd1}) begin
            bad++;
            $display("FAIL branch_with_handshake: got v=%b addr=%h cnt=%0d, want 0/1C/1", v0, a0, c0);
        end
        step(1'b0, 64'h0, 1'b0);
        if (v0 && ip0 == 64'h2C) seen_2c = 1'b1;
        total++;
        if (v0 !== 1'b0) begin
            bad++;
            $display("FAIL branch_early_valid: got v=%b, want 0", v0);
        end
        step(1'b0, 64'h0, 1'b0);
        if (v0 && ip0 == 64'h2C) seen_2c = 1'b1;
        total++;
        if ({v0, ip0, i0, seen_2c} !== {1'b1, 64'h1C, imem(64'h1C), 1'b0}) begin
            bad++;
            $display("FAIL branch_target: got v=%b ipc=%h instr=%h seen2C=%b, want 1/1C/%h/0",
                     v0, ip0, i0, seen_2c, imem(64'h1C));
        end
    endtask

    task automatic test_squash();
        logic seen_10 = 1'b0;
        do_reset();
        step(1'b1, 64'h10, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        if (v0 && ip0 == 64'h10) seen_10 = 1'b1;
        step(1'b1, 64'h3C, 1'b1);
        if (v0 && ip0 == 64'h10) seen_10 = 1'b1;
        total++;
        if ({v0, a0} !== {1'b0, 64'h3C}) begin
            bad++;
            $display("FAIL squash_redirect: got v=%b addr=%h, want 0/3C", v0, a0);
        end
        step(1'b0, 64'h0, 1'b0);
        total++;
        if (v0 !== 1'b0) begin
            bad++;
            $display("FAIL squash_early_valid: got v=%b, want 0", v0);
        end
        step(1'b0, 64'h0, 1'b0);
        total++;
        if ({v0, ip0, i0} !== {1'b1, 64'h3C, 32'hB2048FE9}) begin
            bad++;
            $display("FAIL squash_target: got v=%b ipc=%h instr=%h, want 1/3C/B2048FE9", v0, ip0, i0);
        end
        for (int n = 0; n < 6; n++) begin
            step(1'b0, 64'h0, 1'b1);
            if (v0 && ip0 == 64'h10) seen_10 = 1'b1;
        end
        total++;
        if (seen_10 !== 1'b0 || c0 !== 32'd2) begin
            bad++;
            $display("FAIL squash_no_0x10: got seen10=%b cnt=%0d, want 0/2", seen_10, c0);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b0);
        step(1'b1, 64'h3E, 1'b1);
        total++;
        if ({e0, v0, a0, c0} !== {1'b1, 1'b0, 64'h0, 32'd1}) begin
            bad++;
            $display("FAIL misaligned_entry: got err=%b v=%b addr=%h cnt=%0d, want 1/0/0/1", e0, v0, a0, c0);
        end
        for (int n = 0; n < 6; n++) begin
            step(1'b1, 64'h0, 1'b1);
            total++;
            if ({e0, v0, e1, v1, c0} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd1}) begin
                bad++;
                $display("FAIL misaligned_stuck%0d: got err=%b v=%b err1=%b v1=%b cnt=%0d, want 1/0/1/0/1",
                         n, e0, v0, e1, v1, c0);
            end
        end
        do_reset();
        total++;
        if (e0 !== 1'b0) begin
            bad++;
            $display("FAIL misaligned_reset_clear: got err=%b, want 0", e0);
        end
        step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b0);
        total++;
        if ({v0, ip0, i0} !== {1'b1, 64'h0, 32'hF84003E9}) begin
            bad++;
            $display("FAIL misaligned_restart: got v=%b ipc=%h instr=%h, want 1/0/F84003E9", v0, ip0, i0);
        end
    endtask

    task automatic test_async_reset();
        int cyc_q[$];
        logic [63:0] pc_q[$];
        do_reset();
        repeat (4) step(1'b0, 64'h0, 1'b1);
        repeat (2) step(1'b0, 64'h0, 1'b0);
        total++;
        if ({v0, c0, a0} !== {1'b1, 32'd1, 64'h4}) begin
            bad++;
            $display("FAIL async_precondition: got v=%b cnt=%0d addr=%h, want 1/1/4", v0, c0, a0);
        end
        #3;
        Reset = 1'b1;
        #1;
        total++;
        if ({v0, c0, e0, a0, v1, c1, e1, a1} !== '0) begin
            bad++;
            $display("FAIL async_reset_drop: got v=%b cnt=%0d err=%b addr=%h v1=%b cnt1=%0d err1=%b addr1=%h, want all zero",
                     v0, c0, e0, a0, v1, c1, e1, a1);
        end
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, 64'h0, 1'b1);
            if (v1) begin
                cyc_q.push_back(c);
                pc_q.push_back(ip1);
            end
        end
        total++;
        if (cyc_q.size() != 4) begin
            bad++;
            $display("FAIL lat1_rate: got %0d words in 8 cycles, want 4", cyc_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (cyc_q[k] != 2 * k + 1 || pc_q[k] !== 64'(4 * k)) begin
                    bad++;
                    $display("FAIL lat1_word%0d: got cycle %0d pc %h, want cycle %0d pc %h",
                             k, cyc_q[k], pc_q[k], 2 * k + 1, 4 * k);
                end
            end
        end
        total++;
        if (c1 !== 32'd4) begin
            bad++;
            $display("FAIL lat1_fetchcount: got %0d, want 4", c1);
        end
    endtask

    task automatic test_random();
        logic        red, rdy;
        logic [63:0] rpc;
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) do_reset();
            rdy = ($urandom_range(0, 9) < 7);
            red = ($urandom_range(0, 11) == 0);
            rpc = {56'h0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(red, rpc, rdy);
            total++;
            if ({v0, e0, a0, ip0, i0, c0} !== {m_valid[0], m_err[0], m_pc[0], m_ipc[0], m_instr[0], m_cnt[0]}) begin
                bad++;
                $display("FAIL random_lat2 step %0d: got v=%b err=%b addr=%h ipc=%h instr=%h cnt=%0d, want v=%b err=%b addr=%h ipc=%h instr=%h cnt=%0d",
                         n, v0, e0, a0, ip0, i0, c0,
                         m_valid[0], m_err[0], m_pc[0], m_ipc[0], m_instr[0], m_cnt[0]);
            end
            total++;
            if ({v1, e1, a1, ip1, i1, c1} !== {m_valid[1], m_err[1], m_pc[1], m_ipc[1], m_instr[1], m_cnt[1]}) begin
                bad++;
                $display("FAIL random_lat1 step %0d: got v=%b err=%b addr=%h ipc=%h instr=%h cnt=%0d, want v=%b err=%b addr=%h ipc=%h instr=%h cnt=%0d",
                         n, v1, e1, a1, ip1, i1, c1,
                         m_valid[1], m_err[1], m_pc[1], m_ipc[1], m_instr[1], m_cnt[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_squash();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
